// File: rtl/pipelined_multiplier_unit.sv
// pipelined_multiplier_unit: one-lane RISC-V MUL/MULH/MULHSU/MULHU pipe with a shared stall.
module pipelined_multiplier_unit #(
    parameter int BIT_WIDTH      = 32,
    parameter int PIPELINE_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [BIT_WIDTH-1:0] fuOpA_In,
    input  logic [BIT_WIDTH-1:0] fuOpB_In,
    input  logic                 getUpper,
    input  logic [1:0]           mulCode,
    output logic [BIT_WIDTH-1:0] dataOut
);
    localparam int W2 = 2 * BIT_WIDTH;
    localparam int NS = PIPELINE_DEPTH - 1;

    logic signed [BIT_WIDTH:0] w_a, w_b;
    logic        [W2-1:0]      w_prod;
    logic        [W2-1:0]      r_prod [NS];
    logic        [NS-1:0]      r_upper;

    // A is signed for every code but MULHU; B only for MUL/MULH.
    always_comb begin
        w_a    = {mulCode != 2'b11 && fuOpA_In[BIT_WIDTH-1], fuOpA_In};
        w_b    = {!mulCode[1] && fuOpB_In[BIT_WIDTH-1], fuOpB_In};
        w_prod = W2'(w_a * w_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) r_prod[i] <= '0;
            r_upper <= '0;
        end else if (!stall) begin
            r_prod[0]  <= w_prod;
            r_upper[0] <= getUpper;
            for (int i = 1; i < NS; i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_upper[i] <= r_upper[i-1];
            end
        end
    end

    assign dataOut = r_upper[NS-1] ? r_prod[NS-1][W2-1:BIT_WIDTH] : r_prod[NS-1][BIT_WIDTH-1:0];
endmodule

// File: tb/tb_pipelined_multiplier_unit.sv
// tb_pipelined_multiplier_unit: randomized scoreboard bench for the multiplier pipe.
module tb_pipelined_multiplier_unit;
    localparam int LAT = 2;

    logic        clk = 0;
    logic        rst = 0;
    logic        stall = 0;
    logic        issue = 0;
    logic [31:0] fuOpA_In = 0;
    logic [31:0] fuOpB_In = 0;
    logic        getUpper = 0;
    logic [1:0]  mulCode = 0;
    logic [31:0] dataOut;

    logic [31:0] q[$];
    logic [LAT-1:0] v = '0;
    logic        fresh = 0;
    logic        started = 0;
    logic [31:0] last = 0;
    int          n_vec = 0;
    int          n_err = 0;

    pipelined_multiplier_unit #(.BIT_WIDTH(32), .PIPELINE_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .fuOpA_In(fuOpA_In), .fuOpB_In(fuOpB_In),
        .getUpper(getUpper), .mulCode(mulCode), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    // Reference: exact product from RISC-V signedness rules, then pick a half.
    function automatic logic [31:0] ref_model(logic [31:0] a, logic [31:0] b, logic [1:0] c, logic u);
        longint sa, sb;
        logic [63:0] p;
        sa = (c == 2'b11) ? longint'({32'b0, a}) : longint'($signed(a));
        sb = c[1] ? longint'({32'b0, b}) : longint'($signed(b));
        p  = 64'(sa * sb);
        return u ? p[63:32] : p[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dataOut=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller-side validity tracking; expectations enter the queue at capture.
    always @(posedge clk) begin
        if (rst) begin
            v       <= '0;
            fresh   <= 0;
            started <= 1;
            q.delete();
        end else if (!stall) begin
            v     <= {v[LAT-2:0], issue};
            fresh <= v[LAT-2];
            if (issue) q.push_back(ref_model(fuOpA_In, fuOpB_In, mulCode, getUpper));
        end else begin
            fresh <= 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (fresh) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL underflow: result slot with empty queue, dataOut=%h", dataOut);
                end else begin
                    last = q.pop_front();
                    check("result", dataOut, last);
                end
            end else if (v[LAT-1]) check("hold", dataOut, last);
            else check("idle", dataOut, 32'h0);
        end
    end

    task automatic cyc(input logic r, input logic s, input logic i, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] c, input logic u);
        @(posedge clk);
        #1;
        rst = r; stall = s; issue = i;
        fuOpA_In = (i || r || s) ? a : 32'h0;
        fuOpB_In = (i || r || s) ? b : 32'h0;
        mulCode  = c; getUpper = u;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input logic u);
        cyc(0, 0, 1, a, b, c, u);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic rnd_stall(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, $urandom, $urandom, 2'($urandom), 1'($urandom));
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        op(32'd7, 32'hFFFFFFFD, 2'b00, 0);
        idle(3);
        op(32'h80000000, 32'h80000000, 2'b01, 1);
        op(32'hFFFFFFFF, 32'h00000002, 2'b01, 1);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 0);
        op(32'hFFFFFFFF, 32'h00000002, 2'b10, 1);
        op(32'h00000002, 32'hFFFFFFFF, 2'b10, 1);
        op(32'h12345678, 32'h9ABCDEF0, 2'b00, 1);
        op(32'h12345678, 32'h9ABCDEF0, 2'b11, 0);
        op(32'h12345678, 32'h9ABCDEF0, 2'b10, 1);
        idle(3);
        op(32'hDEADBEEF, 32'hCAFEF00D, 2'b01, 1);
        rnd_stall(3);
        idle(4);
        op(32'h00000003, 32'hFFFFFFFF, 2'b11, 1);
        op(32'h80000001, 32'h7FFFFFFF, 2'b10, 0);
        rnd_stall(3);
        idle(4);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) rnd_stall($urandom_range(1, 3));
            else if ($urandom_range(0, 4) == 0) idle(1);
            else op($urandom, $urandom, 2'($urandom), 1'($urandom));
        end
        op(32'hFFFFFFFF, 32'h00000005, 2'b00, 1);
        op(32'h00000009, 32'h00000009, 2'b11, 0);
        cyc(1, 1, 0, $urandom, $urandom, 2'b01, 1);
        idle(5);
        op(32'h00010000, 32'h00010000, 2'b11, 1);
        op(32'hFFFF0000, 32'h00010000, 2'b00, 0);
        idle(5);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
